// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states,
// bit-counter width and the default bitstream word width.
package cfg_loader_pkg;

  localparam int CNT_W          = 16;
  localparam int DEFAULT_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/config_loader_if.sv
// Bitstream word stream (valid/ready) feeding the configuration loader.
interface config_loader_if
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
);

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/config_loader.sv
// Serialises bitstream words LSB first into a configuration chain of CHAIN_LEN cells.
// Optional readback of the chain tail is built when CFG_READBACK_EN is defined.
module config_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  config_loader_if.slave    s,
  output logic              cfg_bit,
  output logic              cfg_shift_en,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [WB_W-1:0]  WBIT_LAST = WB_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [WB_W-1:0]   wbit_q;
  logic [WORD_W-1:0] sreg_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge config_clk) begin
    if (config_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    s.s_ready    = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_bit      = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        s.s_ready = 1'b1;
        if (s.s_valid) state_d = SHIFT;
      end
      SHIFT: begin
        cfg_shift_en = 1'b1;
        cfg_bit      = sreg_q[0];
        // The chain length check wins, so tail bits of the last word never leave.
        if (bit_cnt_q == LAST_BIT)       state_d = DONE;
        else if (wbit_q == WBIT_LAST)    state_d = LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge config_clk) begin
    if (config_reset) begin
      bit_cnt_q <= '0;
      wbit_q    <= '0;
      sreg_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) bit_cnt_q <= '0;
        LOAD: begin
          if (s.s_valid) begin
            sreg_q <= s.s_data;
            wbit_q <= '0;
          end
        end
        SHIFT: begin
          sreg_q    <= sreg_q >> 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          wbit_q    <= wbit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0] rb_acc_q;
  logic [WORD_W-1:0] rb_word;

  // Current partial word including this cycle's tail sample; bits not yet
  // sampled stay zero because the accumulator is cleared after each emit.
  always_comb begin
    rb_word         = rb_acc_q;
    rb_word[wbit_q] = chain_tail;
  end

  always_ff @(posedge config_clk) begin
    if (config_reset) begin
      rb_acc_q <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state_q == SHIFT) begin
        if (wbit_q == WBIT_LAST || bit_cnt_q == LAST_BIT) begin
          rb_data  <= rb_word;
          rb_valid <= 1'b1;
          rb_acc_q <= '0;
        end else begin
          rb_acc_q <= rb_word;
        end
      end
    end
  end
`else
  logic unused_chain_tail;
  assign unused_chain_tail = chain_tail;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 64, meaning total configuration bits in the target config chain (1..65535).
REQ-002 The block SHALL have parameter WORD_W, default 32, meaning width of each bitstream word.
REQ-003 The block SHALL have port config_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port config_reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a chain load.
REQ-006 The block SHALL have port s_data, input, WORD_W, the bitstream word.
REQ-007 The block SHALL have port s_valid, input, 1, meaning s_data is valid.
REQ-008 The block SHALL have port s_ready, output, 1, meaning the loader accepts s_data this cycle.
REQ-009 The block SHALL have port cfg_bit, output, 1, the serial bit driven to the chain head config_in.
REQ-010 The block SHALL have port cfg_shift_en, output, 1; the chain advances one cell only on cycles where it is high, and integration gates config_clk with it.
REQ-011 The block SHALL have port chain_tail, input, 1, driven from the chain's last config_out.
REQ-012 The block SHALL have port busy, output, 1, high from the start-accept cycle until DONE exits.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse when the last bit has been shifted.
REQ-014 The block SHALL have ports rb_data (output, WORD_W) and rb_valid (output, 1) for readback words.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD next cycle and clear the bit counter to 0.
REQ-017 In LOAD, s_ready SHALL be 1; when s_valid&&s_ready, s_data SHALL be captured into the shift register and the FSM SHALL enter SHIFT next cycle.
REQ-018 In LOAD with s_valid=0, cfg_shift_en SHALL stay 0 and the chain SHALL hold indefinitely with no timeout.
REQ-019 In SHIFT, each cycle SHALL drive cfg_bit with shift-register bit 0 (LSB first, word 0 first) and cfg_shift_en=1, right-shift the register and increment the bit counter.
REQ-020 SHIFT SHALL exit to DONE when the counter reaches CHAIN_LEN; otherwise it SHALL exit to LOAD after WORD_W bits of the current word.
REQ-021 Bits of the final word at or beyond CHAIN_LEN SHALL be discarded and never shifted.
REQ-022 Each word SHALL cost WORD_W+1 cycles, with one LOAD bubble where cfg_shift_en=0.
REQ-023 DONE SHALL last one cycle with done=1, busy=1 and cfg_shift_en=0, then return to IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 s_ready SHALL be 0 outside LOAD; s_data offered then is not consumed.
REQ-026 cfg_bit SHALL be 0 whenever cfg_shift_en=0.
REQ-027 The bit counter SHALL be 16 bits wide and SHALL never wrap for legal CHAIN_LEN.

Reset
REQ-028 config_reset=1 SHALL force IDLE, clear the counter and shift register, and drive s_ready, cfg_bit, cfg_shift_en, busy, done, rb_valid=0 and rb_data=0 on the next edge.
REQ-029 A reset mid-load SHALL abort with no done pulse; the chain contents are then undefined and a new start is required.

Configuration
REQ-030 With CFG_READBACK_EN defined, each SHIFT cycle SHALL sample chain_tail into a readback register LSB first; rb_valid SHALL pulse one cycle with rb_data on every WORD_W samples and on the final partial word, zero-filled in the upper bits.
REQ-031 Without CFG_READBACK_EN, rb_data and rb_valid SHALL be constant 0, chain_tail SHALL be unused, and no readback registers SHALL exist.

Structure
REQ-032 A shared package cfg_loader_pkg SHALL hold the FSM state enum, the counter width constant (16) and the default WORD_W.
REQ-033 The block SHALL be a single module with no sub-modules; the readback logic SHALL be inline under the macro.

Verification
REQ-034 CHAIN_LEN=64 with words 0xA5A5A5A5 then 0x0000FFFF -> cfg_bit sequence 1,0,1,0,0,1,0,1... (64 bits), exactly 64 cfg_shift_en cycles, done at cycle 67 after start.
REQ-035 CHAIN_LEN=40 with words 0xFFFFFFFF then 0x12345678 -> 40 shifts, last 8 bits 0x78 LSB first, upper 24 bits discarded, one done pulse.
REQ-036 s_valid held low for 10 cycles in LOAD -> cfg_shift_en=0 for those cycles, chain unchanged, output sequence unaffected.
REQ-037 start pulsed again mid-SHIFT -> ignored, single done, bit count still CHAIN_LEN.
REQ-038 config_reset asserted at bit 20 -> next cycle all outputs 0 and IDLE; no done; a fresh start reloads correctly.
REQ-039 CFG_READBACK_EN set, chain model of 64 cells preloaded with 0xDEADBEEF_CAFEF00D -> rb_data 0xCAFEF00D then 0xDEADBEEF, each with an rb_valid pulse.
